// File: rtl/frame_update_sched.sv
// Once per frame, walks four update clients in fixed order during vertical blanking,
// then pulses commit so the display latches the new object positions.
module frame_update_sched #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int VBP     = 31,
  parameter int VFP     = 511,
  parameter int TIMEOUT = 255
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       run,
  input  logic [3:0] ack,
  output logic [3:0] req,
  output logic       commit,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic [3:0] timeout_err,
  output logic       overrun
);

  localparam logic [10:0] HP_L  = 11'(HPIXELS);
  localparam logic [10:0] VL_L  = 11'(VLINES);
  localparam logic [9:0]  VBP_L = 10'(VBP);
  localparam logic [9:0]  VFP_L = 10'(VFP);
  localparam logic [7:0]  TO_L  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] timer_q;
  logic [3:0] req_q;
  logic       commit_q;
  logic       busy_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] timeout_err_q;
  logic       overrun_q;

  logic in_frame, trigger, abort, ack_cur, expired;

  // Counter values outside the raster are never treated as trigger/abort points.
  assign in_frame = ({1'b0, hc} < HP_L) && ({1'b0, vc} < VL_L);
  assign trigger  = in_frame && (hc == 10'd0) && (vc == VFP_L);
  assign abort    = in_frame && (hc == 10'd0) && (vc == VBP_L);
  assign ack_cur  = ack[idx_q];
  assign expired  = (timer_q == TO_L);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      timer_q       <= 8'd0;
      req_q         <= 4'b0000;
      commit_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      timeout_err_q <= 4'b0000;
      overrun_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger && run) begin
            state_q <= ISSUE;
            idx_q   <= 2'd0;
            timer_q <= 8'd0;
            req_q   <= 4'b0001;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          // Active video arriving wins over any pending ack or expiry.
          if (abort) begin
            state_q   <= IDLE;
            req_q     <= 4'b0000;
            overrun_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (ack_cur || expired) begin
            if (!ack_cur) timeout_err_q[idx_q] <= 1'b1;
            timer_q <= 8'd0;
            if (idx_q == 2'd3) begin
              state_q     <= COMMIT;
              req_q       <= 4'b0000;
              commit_q    <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
              idx_q <= idx_q + 2'd1;
              req_q <= {req_q[2:0], 1'b0};
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req         = req_q;
  assign commit      = commit_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/frame_update_sched.md
FRAME_UPDATE_SCHED -- requirements
Module: frame_update_sched

Interface
REQ-001 SHALL have parameter HPIXELS, default 800, pixel clocks per line.
REQ-002 SHALL have parameter VLINES, default 521, lines per frame.
REQ-003 SHALL have parameter VBP, default 31, first active line (end of vertical back porch).
REQ-004 SHALL have parameter VFP, default 511, first blanking line (start of vertical front porch).
REQ-005 SHALL have parameter TIMEOUT, default 255, last timer value for a client's request window (8-bit).
REQ-006 SHALL have port dclk input 1: pixel clock, 25 MHz, rising-edge.
REQ-007 SHALL have port clr input 1: reset, asynchronous, active-high.
REQ-008 SHALL have port hc input 10: horizontal counter from the VGA timing generator.
REQ-009 SHALL have port vc input 10: vertical counter from the VGA timing generator.
REQ-010 SHALL have port run input 1: enables starting a new update sequence.
REQ-011 SHALL have port ack input 4: per-client done strobe (0 player, 1 projectiles, 2 enemies, 3 collision).
REQ-012 SHALL have port req output 4: one-hot per-client update request.
REQ-013 SHALL have port commit output 1: one-cycle pulse telling the display to latch new object positions.
REQ-014 SHALL have port busy output 1: high whenever the sequencer is not IDLE.
REQ-015 SHALL have port frame_cnt output 8: count of committed frames.
REQ-016 SHALL have port timeout_err output 4: sticky per-client timeout flags.
REQ-017 SHALL have port overrun output 1: sticky flag for a sequence aborted by active video.

Function
REQ-018 SHALL implement states IDLE, ISSUE, COMMIT; client index idx is 2 bits; timer is 8 bits.
REQ-019 SHALL define trigger as the cycle where hc==0 and vc==VFP, and abort as the cycle where hc==0 and vc==VBP.
REQ-020 IDLE: on trigger with run==1, SHALL enter ISSUE next cycle with idx=0, timer=0, and req=4'b0001.
REQ-021 IDLE: trigger with run==0 SHALL be ignored; a run change outside the trigger cycle SHALL have no effect.
REQ-022 ISSUE: req SHALL equal one-hot of idx; at most one req bit SHALL ever be high.
REQ-023 ISSUE: ack[idx]==1 at cycle t SHALL advance the sequence at t+1.
  - If idx<3: idx+1, timer=0, req moves to the next bit in the same cycle.
  - If idx==3: enter COMMIT with req=0.
REQ-024 ISSUE: when timer==TIMEOUT and ack[idx]==0, SHALL set timeout_err[idx] and advance exactly as in REQ-023.
  - Result: each client sees req for at most TIMEOUT+1 cycles.
REQ-025 ISSUE: otherwise timer SHALL increment by 1 per cycle.
REQ-026 ack bits other than ack[idx], and any ack outside ISSUE, SHALL be ignored.
REQ-027 ack[idx] on the same cycle as timer==TIMEOUT SHALL count as ack; timeout_err SHALL NOT be set.
REQ-028 abort while in ISSUE SHALL take priority over ack and timeout.
  - Next cycle: req=0, overrun=1, state IDLE.
  - No commit is issued; frame_cnt is unchanged.
REQ-029 COMMIT: SHALL drive commit=1 for exactly one cycle, increment frame_cnt modulo 256 (255 wraps to 0), and return to IDLE next cycle.
REQ-030 run going low mid-sequence SHALL NOT stop the sequence; run gates starts only.
REQ-031 a trigger occurring while not IDLE SHALL be ignored.
REQ-032 busy SHALL be 1 in ISSUE and COMMIT, 0 in IDLE.
REQ-033 all outputs SHALL be registered; timeout_err and overrun SHALL clear only on clr.

Reset
REQ-034 clr=1 SHALL asynchronously force state=IDLE, idx=0, timer=0, req=0, commit=0, busy=0, frame_cnt=0, timeout_err=0, overrun=0, including mid-sequence.
REQ-035 after clr is released, the first sequence SHALL start only on the next trigger with run==1.

Verification
REQ-036 run=1, each client acks 3 cycles after its req rises, at vc=511, hc=0:
  - req goes 0001, 0010, 0100, 1000 in order.
  - One commit pulse; frame_cnt 0->1; busy low after commit.
REQ-037 client 2 never acks:
  - req[2] high for exactly 256 cycles.
  - timeout_err=4'b0100; sequence completes; commit pulses; frame_cnt increments.
REQ-038 client 1 holds ack low until abort (vc=31, hc=0):
  - req=0 next cycle; overrun=1; no commit; frame_cnt unchanged.
REQ-039 run=0 at trigger: req stays 0 and busy stays 0 for the whole frame. Also: ack[3] asserted while req=0001 is ignored.
REQ-040 clr pulsed while req=0100: all outputs are 0 immediately. Separately: 256 committed frames wrap frame_cnt 255->0.
